// File: rtl/ssa_mult_seq_if.sv
// Operand/product handshake bundle for the wide-operand multiplier sequencer.
interface ssa_mult_seq_if #(
    parameter int unsigned LIMBS = 2
);
    localparam int unsigned WIDTH = 8 * LIMBS;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/ssa_mult_seq.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier: one 8x8 limb product per cycle
// through a single shared multiplier, shift-accumulated into a 2*WIDTH result.
module ssa_mult_seq #(
    parameter int unsigned LIMBS = 2
) (
    input  logic          clk,
    input  logic          rst,
    ssa_mult_seq_if.slave bus
);
    localparam int unsigned WIDTH = 8 * LIMBS;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam int unsigned SW    = CW + 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

    // Shared 8x8 limb multiplier; the only multiplier in the datapath.
    function automatic logic [15:0] fft_mult(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    logic [1:0]       r_state;
    logic [CW-1:0]    r_i;
    logic [CW-1:0]    r_j;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [PW-1:0]    r_acc;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    w_i_nxt;
    logic [CW-1:0]    w_j_nxt;
    logic [WIDTH-1:0] w_ra_nxt;
    logic [WIDTH-1:0] w_rb_nxt;
    logic [PW-1:0]    w_acc_nxt;

    logic [7:0]       w_limb_a;
    logic [7:0]       w_limb_b;
    logic [15:0]      w_prod16;
    logic [CW:0]      w_pos;
    logic [SW-1:0]    w_shamt;
    logic [PW-1:0]    w_pp;

    // Current limb pair and its weight 2^(8*(i+j)).
    assign w_limb_a = r_ra[{r_i, 3'b000} +: 8];
    assign w_limb_b = r_rb[{r_j, 3'b000} +: 8];
    assign w_prod16 = fft_mult(w_limb_a, w_limb_b);
    assign w_pos    = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt  = {w_pos, 3'b000};
    assign w_pp     = PW'(w_prod16) << w_shamt;

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_ra_nxt    = r_ra;
        w_rb_nxt    = r_rb;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_ra_nxt    = bus.a;
                    w_rb_nxt    = bus.b;
                    w_acc_nxt   = '0;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_acc_nxt = r_acc + w_pp;
                if (r_j == LAST) begin
                    w_j_nxt = '0;
                    if (r_i == LAST) begin
                        w_i_nxt     = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_nxt = r_i + CW'(1);
                    end
                end else begin
                    w_j_nxt = r_j + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_i         <= w_i_nxt;
            r_j         <= w_j_nxt;
            r_ra        <= w_ra_nxt;
            r_rb        <= w_rb_nxt;
            r_acc       <= w_acc_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt == S_CALC);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.p         = r_acc;
endmodule

// File: tb/tb_ssa_mult_seq.sv
// Bench for ssa_mult_seq: directed vector table, reset/back-to-back sequences
// and a randomized regression, all checked against a queued a*b model.
module tb_ssa_mult_seq;
    localparam int unsigned LIMBS = 2;
    localparam int unsigned WIDTH = 8 * LIMBS;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int          NCALC = LIMBS * LIMBS;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [PW-1:0]    p;
        int               stall;
        bit               hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    ssa_mult_seq_if #(.LIMBS(LIMBS)) bus();
    ssa_mult_seq #(.LIMBS(LIMBS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int            checks    = 0;
    int            failures  = 0;
    int            cyc       = 0;
    int            acc_cnt   = 0;
    int            hs_cnt    = 0;
    int            last_hs_cyc;
    logic [PW-1:0] last_hs_p;
    logic [PW-1:0] sb_q[$];
    vec_t          vecs[7];

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Record handshakes seen before the edge, then advance one cycle.
    task automatic cycle();
        if (!rst && bus.in_valid && bus.in_ready) begin
            sb_q.push_back(PW'(bus.a) * PW'(bus.b));
            acc_cnt++;
        end
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got output 0x%0h expected none", bus.p);
            end else begin
                check("sb_product", bus.p, sb_q.pop_front());
            end
            hs_cnt++;
            last_hs_cyc = cyc;
            last_hs_p   = bus.p;
        end
        if (rst) sb_q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string nm);
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            cycle();
            n++;
        end
        bus.out_ready = 1'b0;
        check({nm, "_drain_left"}, PW'(sb_q.size()), 0);
    endtask

    task automatic txn(input vec_t v, input string nm);
        int n;
        int busyc;
        bus.a         = v.a;
        bus.b         = v.b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            cycle();
            n++;
        end
        check({nm, "_ready_at_start"}, PW'(bus.in_ready), 1);
        cycle();
        if (v.hold) begin
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
        end else begin
            bus.in_valid = 1'b0;
            bus.a        = ~v.a;
            bus.b        = ~v.b;
        end
        n     = 0;
        busyc = 0;
        while (!bus.out_valid && n < 50) begin
            if (bus.busy) busyc++;
            cycle();
            n++;
        end
        check({nm, "_latency_cycle"}, PW'(n + 1), PW'(NCALC + 1));
        check({nm, "_busy_cycles"}, PW'(busyc), PW'(NCALC));
        check({nm, "_p"}, bus.p, v.p);
        check({nm, "_in_ready_done"}, PW'(bus.in_ready), 0);
        check({nm, "_busy_done"}, PW'(bus.busy), 0);
        for (int k = 0; k < v.stall; k++) begin
            cycle();
            check({nm, "_stall_p"}, bus.p, v.p);
            check({nm, "_stall_valid"}, PW'(bus.out_valid), 1);
            check({nm, "_stall_in_ready"}, PW'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        check({nm, "_valid_after_hs"}, PW'(bus.out_valid), 0);
        check({nm, "_ready_after_hs"}, PW'(bus.in_ready), 1);
        check({nm, "_no_early_accept"}, PW'(sb_q.size()), 0);
        if (v.hold) begin
            cycle();
            bus.in_valid = 1'b0;
            check({nm, "_held_accept"}, PW'(sb_q.size()), 1);
            drain(nm);
        end
    endtask

    task automatic reset_mid_test();
        int n;
        int spurious;
        bus.a         = 16'h1234;
        bus.b         = 16'h5678;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        check("rst_mid_busy_before", PW'(bus.busy), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid_in_ready", PW'(bus.in_ready), 1);
        check("rst_mid_out_valid", PW'(bus.out_valid), 0);
        check("rst_mid_busy", PW'(bus.busy), 0);
        check("rst_mid_p", bus.p, 0);
        spurious = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) spurious++;
            cycle();
        end
        check("rst_mid_no_valid", PW'(spurious), 0);
        txn('{16'h0003, 16'h0005, 32'h0000000F, 0, 1'b0}, "after_rst");
        // Reset in DONE while the consumer is also accepting.
        bus.a        = 16'h0101;
        bus.b        = 16'h0202;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            cycle();
            n++;
        end
        check("rst_done_reached", PW'(bus.out_valid), 1);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_done_out_valid", PW'(bus.out_valid), 0);
        check("rst_done_p", bus.p, 0);
        check("rst_done_in_ready", PW'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
    endtask

    task automatic back_to_back_test();
        logic [WIDTH-1:0] ops_a[2];
        logic [WIDTH-1:0] ops_b[2];
        int               hcyc[2];
        logic [PW-1:0]    hp[2];
        int               idx;
        int               got;
        int               n;
        int               h;
        bit               accepting;
        ops_a[0] = 16'h0002; ops_b[0] = 16'h0003;
        ops_a[1] = 16'h0100; ops_b[1] = 16'h0100;
        idx = 0; got = 0; n = 0;
        hcyc[0] = 0; hcyc[1] = 0; hp[0] = '0; hp[1] = '0;
        bus.a         = ops_a[0];
        bus.b         = ops_b[0];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (got < 2 && n < 60) begin
            accepting = bus.in_valid && bus.in_ready;
            h = hs_cnt;
            cycle();
            n++;
            if (accepting) begin
                idx++;
                if (idx < 2) begin
                    bus.a = ops_a[idx];
                    bus.b = ops_b[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (hs_cnt != h) begin
                hcyc[got] = last_hs_cyc;
                hp[got]   = last_hs_p;
                got++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_outputs", PW'(got), 2);
        check("b2b_p0", hp[0], 32'h00000006);
        check("b2b_p1", hp[1], 32'h00010000);
        check("b2b_spacing", PW'(hcyc[1] - hcyc[0]), 6);
    endtask

    task automatic random_test();
        int n;
        int target;
        int hs0;
        target = acc_cnt + 1000;
        hs0    = hs_cnt;
        n      = 0;
        while (acc_cnt < target && n < 30000) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.a         = ($urandom_range(7) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
            bus.b         = ($urandom_range(7) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
            bus.out_ready = 1'($urandom_range(1));
            if (acc_cnt == target - 1 && bus.in_valid && bus.in_ready) begin
                cycle();
                bus.in_valid = 1'b0;
            end else begin
                cycle();
            end
            n++;
        end
        bus.in_valid = 1'b0;
        check("rand_accepts", PW'(acc_cnt), PW'(target));
        drain("rand");
        check("rand_outputs", PW'(hs_cnt - hs0), 1000);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 32'h06260060, 0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0};
        vecs[2] = '{16'h0000, 16'hBEEF, 32'h00000000, 0, 1'b0};
        vecs[3] = '{16'h00FF, 16'h0100, 32'h0000FF00, 3, 1'b1};
        vecs[4] = '{16'hFF00, 16'h00FF, 32'h00FE0100, 2, 1'b0};
        vecs[5] = '{16'h8000, 16'h0002, 32'h00010000, 1, 1'b0};
        vecs[6] = '{16'h0001, 16'h0001, 32'h00000001, 0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        cycle();
        cycle();
        check("reset_in_ready", PW'(bus.in_ready), 1);
        check("reset_out_valid", PW'(bus.out_valid), 0);
        check("reset_busy", PW'(bus.busy), 0);
        check("reset_p", bus.p, 0);
        rst = 1'b0;
        cycle();

        for (int v = 0; v < 7; v++) begin
            txn(vecs[v], $sformatf("vec%0d", v));
        end

        reset_mid_test();
        back_to_back_test();
        random_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ssa_mult_seq.md
Name: ssa_mult_seq

Overview:
- Multi-cycle wide-operand multiplier sequencer built around a single instance of the existing combinational 8x8 FFT multiplier (FFTMult).
- Splits WIDTH-bit operands into 8-bit limbs and feeds one limb pair per cycle through the shared FFT multiplier.
- Shift-accumulates the partial products into a 2*WIDTH-bit result.
- Valid/ready handshake on both sides; sits between the SSA operand source and downstream consumers.

Parameters:
- LIMBS, 2, number of 8-bit limbs per operand (legal range 1..8); WIDTH = 8*LIMBS.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept operands
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  2*WIDTH  product a*b, unsigned
- busy  out  1  high in CALC state

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=IDLE; i=j=0; acc=0; latched operands=0.
  - in_ready=1, out_valid=0, busy=0, p=0 (p is driven from acc).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a->ra and b->rb, clear acc, i=j=0, go to CALC.
- CALC:
  - in_ready=0, busy=1. in_valid is ignored.
  - Each cycle, limbs ra[8i+:8] and rb[8j+:8] drive the FFTMult inputs combinationally.
  - Register update: acc <= acc + (prod16 << 8*(i+j)).
  - Iteration order: j inner, i outer. j wraps to 0 at LIMBS-1 and increments i.
  - After pair (LIMBS-1, LIMBS-1) is accumulated, go to DONE.
  - Exactly LIMBS^2 CALC cycles; no zero-limb skipping.
- DONE:
  - out_valid=1, p=acc, held stable while out_ready=0. in_ready=0.
  - On out_valid&&out_ready: go to IDLE next edge; out_valid drops that edge.
- Latency: accept edge at cycle 0 -> out_valid high from cycle LIMBS^2+1 (cycle 5 for LIMBS=2).
- Throughput: one product per LIMBS^2+2 cycles with no back-pressure. A new accept is possible in the cycle after the output handshake.
- Arithmetic:
  - acc is 2*WIDTH bits and the final sum cannot overflow.
  - Each shifted partial product is zero-extended to 2*WIDTH before the add.
  - Intermediate sums never exceed a*b, so no truncation occurs.
- Boundary conditions:
  - Operands are captured only at accept. Changes on a/b after accept do not affect the result.
  - in_valid held high across a transaction produces exactly one accept per IDLE visit.
  - rst asserted in any state, including mid-CALC or DONE with out_ready=0, returns all registers to reset values on the next edge. The pending result is discarded and no out_valid pulse follows.
  - rst has priority over the in_valid and out_ready handshakes in the same cycle.
  - LIMBS=1: a single CALC cycle; degenerates to a registered 8x8 product.

Test Plan:
- LIMBS=2, a=0x1234, b=0x5678, out_ready=1 -> out_valid first high 5 cycles after accept edge; p=0x06260060; busy high exactly 4 cycles.
- a=0xFFFF, b=0xFFFF -> p=0xFFFE0001. Also a=0x0000, b=0xBEEF -> p=0x00000000 after the same 4 CALC cycles.
- Back-pressure:
  - Stimulus: a=0x00FF, b=0x0100, out_ready=0 for 3 cycles in DONE, in_valid=1 with new operands throughout.
  - Response: p=0x0000FF00 stable; in_ready=0; no second accept until the cycle after the out handshake.
- Reset mid-operation: assert rst during the 2nd CALC cycle -> next cycle state=IDLE, in_ready=1, out_valid=0, p=0; the following transaction a=3, b=5 yields p=15.
- Back-to-back, in_valid held high, operand stream (0x0002,0x0003), (0x0100,0x0100) -> products 0x00000006 then 0x00010000, outputs spaced 6 cycles apart.
- Random regression, 1000 operand pairs with randomized out_ready -> p matches the a*b reference model and ordering is preserved.
